// File: rtl/mcycle_processor_if.sv
// Instruction/immediate word stream into the multi-cycle core.
// The producer drives the word and valid; the core answers with ready.
interface mcycle_processor_if #(
  parameter int W = 9
);
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/mcycle_processor.sv
// Multi-cycle register-machine core: eight opcodes over a shared bus with an
// A/G accumulator pair, a display register H and a valid/ready word input.
module mcycle_processor #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  mcycle_processor_if.slave in_bus,
  output logic [DATA_W-1:0] disp_out,
  output logic              disp_valid,
  output logic [3:0]        tick,
  output logic              busy,
  output logic              instr_done,
  output logic              z_flag,
  output logic              n_flag
);
  localparam int RIDX = $clog2(NREG);
  localparam int IN_W = 3 + 2 * RIDX;
  localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W'(DATA_W);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, IMM, WB} state_t;
  typedef enum logic [2:0] {
    OP_DISP, OP_ADD, OP_ADD_I, OP_SUB, OP_MUL, OP_SRL, OP_SLL, OP_MOV_I
  } op_t;

  state_t            state, nxt;
  logic [IN_W-1:0]   ir;
  logic [DATA_W-1:0] a, g, h;
  logic [DATA_W-1:0] regs [NREG];
  logic              disp_pulse;

  op_t               op;
  logic [RIDX-1:0]   rx, ry;
  logic [DATA_W-1:0] b, imm_ext, alu, g_new;
  logic              accept;

  assign op      = op_t'(ir[IN_W-1 -: 3]);
  assign rx      = ir[2*RIDX-1 -: RIDX];
  assign ry      = ir[RIDX-1:0];
  assign b       = regs[ry];
  assign imm_ext = DATA_W'($signed(in_bus.din));

  assign in_bus.din_ready = en & ((state == FETCH) | (state == IMM));
  assign accept           = in_bus.din_ready & in_bus.din_valid;

  assign disp_out   = h;
  assign disp_valid = en & disp_pulse;
  assign instr_done = en & (((state == DECODE) & (op == OP_DISP)) |
                            ((state == IMM) & accept & (op == OP_MOV_I)) |
                            (state == WB));

  function automatic logic [3:0] tick_of(state_t s);
    case (s)
      FETCH:       return 4'b0001;
      DECODE:      return 4'b0010;
      EXEC, IMM:   return 4'b0100;
      default:     return 4'b1000;
    endcase
  endfunction

  // Shift amounts are unsigned register values; anything past the width clears.
  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_MUL:  alu = a * b;
      OP_SRL:  alu = (b >= SHIFT_LIM) ? '0 : (a >> b);
      OP_SLL:  alu = (b >= SHIFT_LIM) ? '0 : (a << b);
      default: alu = '0;
    endcase
  end

  assign g_new = (state == IMM) ? (a + imm_ext) : alu;

  always_comb begin
    nxt = state;
    case (state)
      FETCH:  if (accept) nxt = DECODE;
      DECODE: begin
        case (op)
          OP_DISP:           nxt = FETCH;
          OP_MOV_I, OP_ADD_I: nxt = IMM;
          default:           nxt = EXEC;
        endcase
      end
      IMM:    if (accept) nxt = (op == OP_MOV_I) ? FETCH : WB;
      EXEC:   nxt = WB;
      default: nxt = FETCH;
    endcase
  end

  // Everything freezes while en is low, including the pending display pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      tick       <= 4'b0001;
      busy       <= 1'b0;
      ir         <= '0;
      a          <= '0;
      g          <= '0;
      h          <= '0;
      z_flag     <= 1'b0;
      n_flag     <= 1'b0;
      disp_pulse <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (en) begin
      state      <= nxt;
      tick       <= tick_of(nxt);
      busy       <= (nxt != FETCH);
      disp_pulse <= (state == DECODE) & (op == OP_DISP);
      case (state)
        FETCH:  if (accept) ir <= in_bus.din;
        DECODE: begin
          if (op == OP_DISP) h <= regs[rx];
          else               a <= regs[rx];
        end
        IMM: begin
          if (accept) begin
            if (op == OP_MOV_I) begin
              regs[rx] <= imm_ext;
            end else begin
              g      <= g_new;
              z_flag <= (g_new == '0);
              n_flag <= g_new[DATA_W-1];
            end
          end
        end
        EXEC: begin
          g      <= g_new;
          z_flag <= (g_new == '0);
          n_flag <= g_new[DATA_W-1];
        end
        WB:      regs[rx] <= g;
        default: ;
      endcase
    end
  end
endmodule
